cla_adder_reg: RTL and testbench
================================

Name: cla_adder_reg

Overview:
- Parameterised two's-complement/unsigned adder for the RISC-V datapath: S = X + Y + Cin, with carry-out.
- Built from 4-bit carry-lookahead blocks chained by block carry.
- Result and flags are registered, giving one-cycle latency, with a valid bit travelling alongside.
- Used by the ALU and by the PC/branch-target logic.

Parameters:
- SIZE, 32, operand/result width in bits; must be a multiple of BLOCK and ≥ BLOCK.
- BLOCK, 4, width of each carry-lookahead group; fixed at 4 in this revision.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on X/Y/Cin are valid this cycle.
- X  input  SIZE  operand A.
- Y  input  SIZE  operand B.
- Cin  input  1  carry-in (1 for subtraction with inverted Y).
- S  output  SIZE  registered sum, bits [SIZE-1:0].
- Cout  output  1  registered carry out of bit SIZE-1.
- out_valid  output  1  S/Cout hold a result computed from the in_valid cycle.

Behaviour:
- Reset:
  - rst_n low asynchronously forces S=0, Cout=0, out_valid=0 (and V=0 when present).
  - Release is synchronous to the next clk edge.
  - Reset asserted mid-operation discards the in-flight result.
- Arithmetic:
  - {Cout,S} = X + Y + Cin, computed modulo 2^(SIZE+1).
  - No sign extension; operands are interpreted by the consumer as signed or unsigned.
- Carry-lookahead structure:
  - Each BLOCK slice computes g_i = X_i&Y_i, p_i = X_i^Y_i, internal carries via lookahead, sum s_i = p_i ^ c_i, plus group generate G and propagate P.
  - Block carry-out = G | (P & c_in_block).
  - Slice 0 takes Cin.
  - Cout = carry out of the last slice.
- Timing:
  - Capture on rising clk when in_valid=1: S, Cout updated next edge.
  - out_valid = in_valid delayed one cycle.
  - Latency exactly 1 cycle; throughput 1 result per cycle.
- When in_valid=0:
  - S and Cout hold their previous values.
  - out_valid drops to 0 on the next edge.
- No backpressure; the consumer must accept the result in the out_valid cycle.
- Wrap-around:
  - All-ones + 0 + Cin=1 gives S=0, Cout=1.
  - Cout is the unsigned carry, not signed overflow.

Optional Feature:
- Macro: CLA_ADDER_OVERFLOW_EN.
- Defined:
  - Extra output port V (1 bit, registered alongside S).
  - V = (X[SIZE-1]==Y[SIZE-1]) && (S_next[SIZE-1]!=X[SIZE-1]), i.e. signed two's-complement overflow.
  - V resets to 0 and holds when in_valid=0.
- Undefined:
  - Port V does not exist.
  - No overflow logic is synthesised.

Decomposition:
- Shared package adder_pkg:
  - localparam CLA_BLOCK = 4.
  - Function/typedef for block generate/propagate pair (gp_t: logic g, logic p).
- Sub-module cla4_block:
  - 4-bit lookahead slice with inputs x[3:0], y[3:0], ci.
  - Outputs s[3:0], co, G, P.
  - Instantiated SIZE/BLOCK times in a generate loop.
- The top holds the output registers and the valid pipeline.

Test Plan:
- 500 + (-450):
  - Stimulus: X=32'h000001F4, Y=32'hFFFFFE3E, Cin=0, in_valid=1.
  - Response one cycle later: S=32'h00000032 (50), Cout=1, out_valid=1, V=0.
- 500 + 450:
  - Stimulus: X=32'h000001F4, Y=32'h000001C2, Cin=0.
  - Response: S=32'h000003B6 (950), Cout=0.
- 950 + (-1000):
  - Stimulus: X=32'h000003B6, Y=32'hFFFFFC18, Cin=0.
  - Response: S=32'hFFFFFFCE (-50), Cout=0, V=0.
- Carry chain through every slice:
  - Stimulus: X=32'hFFFFFFFF, Y=0, Cin=1.
  - Response: S=0, Cout=1.
- Signed overflow:
  - Stimulus: X=32'h7FFFFFFF, Y=1, Cin=0.
  - Response: S=32'h80000000, Cout=0, V=1 when CLA_ADDER_OVERFLOW_EN is defined.
- Hold and reset:
  - Stimulus: in_valid=0 for 3 cycles, then rst_n pulsed low between clock edges.
  - Response: S holds the last result with out_valid=0; during reset S, Cout and out_valid go to 0 immediately without waiting for clk.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the carry-lookahead adder.
// Optional signed-overflow flag is enabled elsewhere by CLA_ADDER_OVERFLOW_EN.
package adder_pkg;

    localparam int unsigned CLA_BLOCK = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Carry out of a lookahead group given its generate/propagate pair.
    function automatic logic block_carry(input gp_t gp, input logic ci);
        return gp.g | (gp.p & ci);
    endfunction

endpackage

// File: rtl/cla_adder_reg_if.sv
// Operand/result bus of cla_adder_reg; carries V only when CLA_ADDER_OVERFLOW_EN is defined.
interface cla_adder_reg_if #(
    parameter int unsigned SIZE = 32
);
    logic            in_valid;
    logic [SIZE-1:0] X;
    logic [SIZE-1:0] Y;
    logic            Cin;
    logic [SIZE-1:0] S;
    logic            Cout;
    logic            out_valid;
`ifdef CLA_ADDER_OVERFLOW_EN
    logic            V;

    modport master (output in_valid, X, Y, Cin, input S, Cout, out_valid, V);
    modport slave  (input in_valid, X, Y, Cin, output S, Cout, out_valid, V);
`else
    modport master (output in_valid, X, Y, Cin, input S, Cout, out_valid);
    modport slave  (input in_valid, X, Y, Cin, output S, Cout, out_valid);
`endif
endinterface

// File: rtl/cla4_block.sv
// 4-bit carry-lookahead slice: sum, carry-out and group generate/propagate.
module cla4_block
    import adder_pkg::*;
(
    input  logic [CLA_BLOCK-1:0] x,
    input  logic [CLA_BLOCK-1:0] y,
    input  logic                 ci,
    output logic [CLA_BLOCK-1:0] s,
    output logic                 co,
    output logic                 G,
    output logic                 P
);
    logic [CLA_BLOCK-1:0] g;
    logic [CLA_BLOCK-1:0] p;
    logic [CLA_BLOCK-1:0] c;

    always_comb begin
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        P    = &p;
        s    = p ^ c;
        co   = block_carry(gp_t'{g: G, p: P}, ci);
    end

endmodule

// File: rtl/cla_adder_reg.sv
// Registered adder {Cout,S} = X + Y + Cin built from chained 4-bit lookahead slices.
// Defining CLA_ADDER_OVERFLOW_EN adds the registered signed-overflow flag V.
module cla_adder_reg
    import adder_pkg::*;
#(
    parameter int unsigned SIZE  = 32,
    parameter int unsigned BLOCK = CLA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_adder_reg_if.slave   bus
);
    localparam int unsigned NB = SIZE / BLOCK;

    logic [NB:0]     carry;
    logic [NB-1:0]   blk_g;
    logic [NB-1:0]   blk_p;
    logic [SIZE-1:0] s_d;
    logic [SIZE-1:0] s_q;
    logic            cout_d;
    logic            cout_q;
    logic            out_valid_q;
    logic            unused_gp;

    assign carry[0] = bus.Cin;

    // Slices ripple the block carry; each slice resolves its own carries by lookahead.
    for (genvar k = 0; k < NB; k++) begin : g_blk
        cla4_block u_blk (
            .x  (bus.X[k*BLOCK +: BLOCK]),
            .y  (bus.Y[k*BLOCK +: BLOCK]),
            .ci (carry[k]),
            .s  (s_d[k*BLOCK +: BLOCK]),
            .co (carry[k+1]),
            .G  (blk_g[k]),
            .P  (blk_p[k])
        );
    end

    assign cout_d    = carry[NB];
    assign unused_gp = ^{blk_g, blk_p};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s_q    <= s_d;
                cout_q <= cout_d;
            end
        end
    end

    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.out_valid = out_valid_q;

`ifdef CLA_ADDER_OVERFLOW_EN
    logic v_d;
    logic v_q;

    // Like-signed operands producing an opposite-signed sum.
    assign v_d = (bus.X[SIZE-1] == bus.Y[SIZE-1]) && (s_d[SIZE-1] != bus.X[SIZE-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else if (bus.in_valid) begin
            v_q <= v_d;
        end
    end

    assign bus.V = v_q;
`endif

endmodule

// File: tb/tb_cla_adder_reg.sv
// Bench for cla_adder_reg: directed vector table, hold/reset sequences, randomized model check.
// Checks V as well when built with CLA_ADDER_OVERFLOW_EN.
module tb_cla_adder_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] exp_s;
    logic        exp_cout;
    logic        exp_v;
    logic        exp_ov;

    typedef struct {
        string       name;
        logic [31:0] x;
        logic [31:0] y;
        logic        cin;
        logic [31:0] s;
        logic        cout;
        logic        v;
    } vec_t;

    vec_t tbl [5];

    cla_adder_reg_if #(.SIZE(32)) bus ();

    cla_adder_reg #(.SIZE(32), .BLOCK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: plain wide arithmetic; overflow means the true signed sum leaves the 32-bit range.
    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic cin, input logic valid);
        logic [32:0] usum;
        longint      ssum;
        bus.X        = x;
        bus.Y        = y;
        bus.Cin      = cin;
        bus.in_valid = valid;
        @(negedge clk);
        if (valid) begin
            usum     = 33'(x) + 33'(y) + 33'(cin);
            exp_s    = usum[31:0];
            exp_cout = usum[32];
            ssum     = longint'($signed(x)) + longint'($signed(y)) + longint'(cin);
            exp_v    = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
        end
        exp_ov = valid;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".S"}, 33'(bus.S), 33'(exp_s));
        check({tag, ".Cout"}, 33'(bus.Cout), 33'(exp_cout));
        check({tag, ".out_valid"}, 33'(bus.out_valid), 33'(exp_ov));
`ifdef CLA_ADDER_OVERFLOW_EN
        check({tag, ".V"}, 33'(bus.V), 33'(exp_v));
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".S"}, 33'(bus.S), 33'd0);
        check({tag, ".Cout"}, 33'(bus.Cout), 33'd0);
        check({tag, ".out_valid"}, 33'(bus.out_valid), 33'd0);
`ifdef CLA_ADDER_OVERFLOW_EN
        check({tag, ".V"}, 33'(bus.V), 33'd0);
`endif
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        logic [31:0] held;

        checks = 0;
        errors = 0;
        tbl[0] = '{"p500_m450",  32'h000001F4, 32'hFFFFFE3E, 1'b0, 32'h00000032, 1'b1, 1'b0};
        tbl[1] = '{"p500_p450",  32'h000001F4, 32'h000001C2, 1'b0, 32'h000003B6, 1'b0, 1'b0};
        tbl[2] = '{"p950_m1000", 32'h000003B6, 32'hFFFFFC18, 1'b0, 32'hFFFFFFCE, 1'b0, 1'b0};
        tbl[3] = '{"carry_all",  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[4] = '{"sgn_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.X        = '0;
        bus.Y        = '0;
        bus.Cin      = 1'b0;
        exp_s = '0; exp_cout = 1'b0; exp_v = 1'b0; exp_ov = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back directed vectors, one result per cycle.
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].x, tbl[i].y, tbl[i].cin, 1'b1);
            check({tbl[i].name, ".S"}, 33'(bus.S), 33'(tbl[i].s));
            check({tbl[i].name, ".Cout"}, 33'(bus.Cout), 33'(tbl[i].cout));
            check({tbl[i].name, ".out_valid"}, 33'(bus.out_valid), 33'd1);
`ifdef CLA_ADDER_OVERFLOW_EN
            check({tbl[i].name, ".V"}, 33'(bus.V), 33'(tbl[i].v));
`endif
        end

        // Hold: idle inputs with changing operands must not disturb the result.
        held = tbl[4].s;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, 1'b1, 1'b0);
            check("hold.S", 33'(bus.S), 33'(held));
            check("hold.out_valid", 33'(bus.out_valid), 33'd0);
            check("hold.Cout", 33'(bus.Cout), 33'(tbl[4].cout));
        end

        // Reset pulsed between edges clears outputs without a clock.
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        #1 rst_n = 1'b1;
        exp_s = '0; exp_cout = 1'b0; exp_v = 1'b0; exp_ov = 1'b0;
        @(negedge clk);
        check_zero("after_rst");

        // Reset held across the capture edge discards the in-flight operation.
        bus.X = 32'h7FFFFFFF; bus.Y = 32'hFFFFFFFF; bus.Cin = 1'b1; bus.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zero("rst_discard");
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        check_zero("rst_discard_idle");

        // Randomized traffic with gaps and carry-heavy operands.
        for (int i = 0; i < 400; i++) begin
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = ~rx;
                1: rx = 32'hFFFFFFFF;
                2: begin rx = {1'b0, rx[30:0]}; ry = {1'b0, ry[30:0]}; end
                3: begin rx = {1'b1, rx[30:0]}; ry = {1'b1, ry[30:0]}; end
                default: ;
            endcase
            drive(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
